// File: rtl/exp_align_pipeline.sv
// Exponent alignment pipeline: finds the largest lane exponent of a vector,
// the lowest lane holding it, and each lane's saturated shift to reach it.
// Two registered stages (S1 = captured exponents, S2 = results) with
// valid/ready flow control that sustains one vector per cycle.
// Optional build macro EXP_ALIGN_ZERO_MASK_EN: zero exponents drop out of
// the maximum search and get a forced, flagged MAX_SHIFT offset.
module exp_align_pipeline #(
    parameter int EXP_WIDTH = 4,
    parameter int LANES     = 4,
    parameter int MAX_SHIFT = 7
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [EXP_WIDTH*LANES-1:0]   in_exp,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [EXP_WIDTH-1:0]         max_exp,
    output logic [$clog2(LANES)-1:0]     max_idx,
    output logic [EXP_WIDTH*LANES-1:0]   exp_offset,
    output logic [LANES-1:0]             sat_mask
);

    localparam int IDX_W = $clog2(LANES);
    localparam int NODES = 2*LANES - 1;
    localparam logic [EXP_WIDTH-1:0] SHIFT_CAP = EXP_WIDTH'(MAX_SHIFT);

    logic                       s1Valid_q, s1Valid_d;
    logic [EXP_WIDTH*LANES-1:0] s1Exp_q, s1Exp_d;
    logic                       s2Valid_q, s2Valid_d;
    logic [EXP_WIDTH-1:0]       maxExp_q, maxExp_d;
    logic [IDX_W-1:0]           maxIdx_q, maxIdx_d;
    logic [EXP_WIDTH*LANES-1:0] offset_q, offset_d;
    logic [LANES-1:0]           satMask_q, satMask_d;

    logic                       s2Advance;
    logic [LANES-1:0]           laneActive;
    logic [EXP_WIDTH-1:0]       maxExpComb;
    logic [IDX_W-1:0]           maxIdxComb;
    logic [EXP_WIDTH*LANES-1:0] offsetComb;
    logic [LANES-1:0]           satComb;

    // Decide which lanes take part in the maximum search.
    always_comb begin
        laneActive = '1;
        for (int i = 0; i < LANES; i++) begin
`ifdef EXP_ALIGN_ZERO_MASK_EN
            laneActive[i] = (s1Exp_q[i*EXP_WIDTH +: EXP_WIDTH] != '0);
`else
            laneActive[i] = 1'b1;
`endif
        end
    end

    // Balanced comparator tree over the S1 lanes; on ties the left (lower-lane) side wins.
    always_comb begin : maxTree
        logic [EXP_WIDTH-1:0] tExp [NODES];
        logic [IDX_W-1:0]     tIdx [NODES];
        logic                 tVld [NODES];
        logic                 takeLeft;
        for (int n = 0; n < NODES; n++) begin
            tExp[n] = '0;
            tIdx[n] = '0;
            tVld[n] = 1'b0;
        end
        takeLeft = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            tExp[LANES-1+i] = s1Exp_q[i*EXP_WIDTH +: EXP_WIDTH];
            tIdx[LANES-1+i] = IDX_W'(i);
            tVld[LANES-1+i] = laneActive[i];
        end
        for (int n = LANES-2; n >= 0; n--) begin
            takeLeft = tVld[2*n+1] && (!tVld[2*n+2] || (tExp[2*n+1] >= tExp[2*n+2]));
            if (takeLeft) begin
                tExp[n] = tExp[2*n+1];
                tIdx[n] = tIdx[2*n+1];
            end else begin
                tExp[n] = tExp[2*n+2];
                tIdx[n] = tIdx[2*n+2];
            end
            tVld[n] = tVld[2*n+1] || tVld[2*n+2];
        end
        if (tVld[0]) begin
            maxExpComb = tExp[0];
            maxIdxComb = tIdx[0];
        end else begin
            maxExpComb = '0;
            maxIdxComb = '0;
        end
    end

    // Per-lane distance to the maximum, clipped at the shift ceiling.
    always_comb begin : offsets
        logic [EXP_WIDTH-1:0] raw;
        offsetComb = '0;
        satComb    = '0;
        raw        = '0;
        for (int i = 0; i < LANES; i++) begin
            raw = maxExpComb - s1Exp_q[i*EXP_WIDTH +: EXP_WIDTH];
            if (!laneActive[i]) begin
                offsetComb[i*EXP_WIDTH +: EXP_WIDTH] = SHIFT_CAP;
                satComb[i] = 1'b1;
            end else if (raw > SHIFT_CAP) begin
                offsetComb[i*EXP_WIDTH +: EXP_WIDTH] = SHIFT_CAP;
                satComb[i] = 1'b1;
            end else begin
                offsetComb[i*EXP_WIDTH +: EXP_WIDTH] = raw;
            end
        end
    end

    // Flow control: S2 moves when empty or drained; S1 moves only with S2.
    always_comb begin
        s2Advance = !s2Valid_q || out_ready;
        in_ready  = !s1Valid_q || s2Advance;

        s1Valid_d = s1Valid_q;
        s1Exp_d   = s1Exp_q;
        s2Valid_d = s2Valid_q;
        maxExp_d  = maxExp_q;
        maxIdx_d  = maxIdx_q;
        offset_d  = offset_q;
        satMask_d = satMask_q;

        if (in_ready) begin
            s1Valid_d = in_valid;
            if (in_valid) begin
                s1Exp_d = in_exp;
            end
        end
        if (s2Advance) begin
            s2Valid_d = s1Valid_q;
            if (s1Valid_q) begin
                maxExp_d  = maxExpComb;
                maxIdx_d  = maxIdxComb;
                offset_d  = offsetComb;
                satMask_d = satComb;
            end
        end
    end

    // Pipeline registers; reset drops in-flight vectors and zeroes all data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1Valid_q <= 1'b0;
            s1Exp_q   <= '0;
            s2Valid_q <= 1'b0;
            maxExp_q  <= '0;
            maxIdx_q  <= '0;
            offset_q  <= '0;
            satMask_q <= '0;
        end else begin
            s1Valid_q <= s1Valid_d;
            s1Exp_q   <= s1Exp_d;
            s2Valid_q <= s2Valid_d;
            maxExp_q  <= maxExp_d;
            maxIdx_q  <= maxIdx_d;
            offset_q  <= offset_d;
            satMask_q <= satMask_d;
        end
    end

    assign out_valid  = s2Valid_q;
    assign max_exp    = maxExp_q;
    assign max_idx    = maxIdx_q;
    assign exp_offset = offset_q;
    assign sat_mask   = satMask_q;

endmodule

// File: doc/exp_align_pipeline.md
EXP_ALIGN_PIPELINE -- requirements
Module: exp_align_pipeline

Interface
REQ-001 SHALL have parameter EXP_WIDTH, default 4: exponent width in bits.
REQ-002 SHALL have parameter LANES, default 4: exponent lane count, a power of two, at least 2.
REQ-003 SHALL have parameter MAX_SHIFT, default 7: offset saturation ceiling, at most 2^EXP_WIDTH-1.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1: input vector present.
REQ-007 SHALL have port in_ready, output, 1: block accepts input this cycle.
REQ-008 SHALL have port in_exp, input, EXP_WIDTH*LANES: packed exponents; lane i at bits [i*EXP_WIDTH +: EXP_WIDTH].
REQ-009 SHALL have port out_valid, output, 1: result present.
REQ-010 SHALL have port out_ready, input, 1: downstream consumes the result.
REQ-011 SHALL have port max_exp, output, EXP_WIDTH: maximum lane exponent.
REQ-012 SHALL have port max_idx, output, clog2(LANES): lowest lane index holding max_exp.
REQ-013 SHALL have port exp_offset, output, EXP_WIDTH*LANES: per-lane alignment shift, packed as in_exp.
REQ-014 SHALL have port sat_mask, output, LANES: bit i set when lane i's offset was clipped or forced.

Function
REQ-015 SHALL accept a vector on a cycle where in_valid and in_ready are both 1.
REQ-016 SHALL be a two-stage pipeline. S1 registers the input exponents. S2 registers max_exp, max_idx, exp_offset and sat_mask.
REQ-017 SHALL raise out_valid 2 cycles after acceptance when no stall occurs, and sustain 1 vector per cycle.
REQ-018 SHALL advance S2 when S2 is empty or out_ready=1; S1 SHALL advance into S2 only when S2 advances.
REQ-019 SHALL drive in_ready = !s1_valid || s2_advance, combinationally, with no dependency on in_valid.
REQ-020 SHALL hold all outputs stable while out_valid=1 and out_ready=0.
REQ-021 SHALL compute max_exp as the unsigned maximum over participating lanes, using a balanced comparator tree of depth log2(LANES).
REQ-022 SHALL set max_idx to the lowest lane index among ties.
REQ-023 SHALL compute raw offset = max_exp - exp_i, unsigned, EXP_WIDTH bits.
REQ-024 SHALL output min(raw, MAX_SHIFT), and SHALL set sat_mask[i] when raw > MAX_SHIFT.
REQ-025 SHALL give the max lane an offset of 0.
REQ-026 SHALL handle simultaneous acceptance and output consumption with no bubble and no loss of data.

Reset
REQ-027 SHALL, on rst=1, asynchronously clear the S1 and S2 valid flags and all data registers to 0: out_valid=0, max_exp=0, max_idx=0, exp_offset=0, sat_mask=0.
REQ-028 SHALL hold in_ready=1 while rst is deasserted and the pipeline is empty.
REQ-029 SHALL discard in-flight vectors on reset mid-operation; no output SHALL appear for them after reset.

Configuration
REQ-030 SHALL support macro EXP_ALIGN_ZERO_MASK_EN:
- When defined: lanes with exponent 0 are excluded from the max and from max_idx; their offset is forced to MAX_SHIFT and their sat_mask bit is set.
- When defined and all lanes are 0: max_exp=0, max_idx=0, all offsets=MAX_SHIFT, sat_mask all ones.
- When undefined: exponent 0 is treated as an ordinary value.

Verification (LANES=4, EXP_WIDTH=4, MAX_SHIFT=7; lanes listed lane3..lane0)
REQ-031 SHALL cover the basic single-vector case.
- Stimulus: in_exp={3,9,9,1}, out_ready=1.
- Response: 2 cycles later max_exp=9, max_idx=1, offsets={6,0,0,7}, sat_mask=0001.
REQ-032 SHALL cover back-to-back streaming.
- Stimulus: three vectors on consecutive cycles, out_ready=1.
- Response: out_valid high on cycles 2, 3 and 4 with matching results; in_ready stays 1.
REQ-033 SHALL cover backpressure.
- Stimulus: out_ready=0 with in_valid held at 1.
- Response: two vectors accepted, then in_ready=0; outputs frozen. On out_ready=1, results emerge in order with none lost.
REQ-034 SHALL cover the zero-mask feature.
- Stimulus: in_exp={0,5,0,2}.
- Response with EXP_ALIGN_ZERO_MASK_EN: max_exp=5, max_idx=2, offsets={7,0,7,3}, sat_mask=1010.
- Response without the macro: offsets={5,0,5,3}, sat_mask=0000.
REQ-035 SHALL cover reset mid-operation.
- Stimulus: rst asserted 1 cycle after acceptance.
- Response: out_valid=0 immediately; no result for that vector after release.
